alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 121 ++++++++++++
 tb/tb_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: one operation sampled per clock, result and flags valid after the edge.
// Optional macro ALU_EXT_FLAGS_EN adds registered Negative and Overflow outputs.
module alu #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [2:0]        ALU_Code,
   output logic [DATA_W-1:0] ALU_Out,
   output logic              Carry,
`ifdef ALU_EXT_FLAGS_EN
   output logic              Negative,
   output logic              Overflow,
`endif
   output logic              isZero
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   localparam int MSB = DATA_W - 1;

   op_e               op;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W:0]   diff_w;
   logic [DATA_W-1:0] res_d;
   logic              carry_d;
   logic              zero_d;
   logic [DATA_W-1:0] res_q;
   logic              carry_q;
   logic              zero_q;

   assign op = op_e'(ALU_Code);

   // Extra top bit of the widened sum/difference is carry-out resp. borrow.
   assign sum_w  = {1'b0, A} + {1'b0, B};
   assign diff_w = {1'b0, A} - {1'b0, B};

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      case (op)
         OP_ADD: {carry_d, res_d} = sum_w;
         OP_SUB: {carry_d, res_d} = diff_w;
         OP_AND: res_d = A & B;
         OP_OR:  res_d = A | B;
         OP_XOR: res_d = A ^ B;
         OP_NOT: res_d = ~A;
         OP_SHL: begin
            res_d   = {A[MSB-1:0], 1'b0};
            carry_d = A[MSB];
         end
         OP_SHR: begin
            res_d   = {1'b0, A[MSB:1]};
            carry_d = A[0];
         end
         default: begin
            res_d   = '0;
            carry_d = 1'b0;
         end
      endcase
   end

   assign zero_d = (res_d == '0);

`ifdef ALU_EXT_FLAGS_EN
   logic neg_d, ovf_d, neg_q, ovf_q;

   // Signed overflow: operands that agree in sign (ADD) or differ (SUB) yet the result sign flips.
   always_comb begin
      ovf_d = 1'b0;
      case (op)
         OP_ADD:  ovf_d = (A[MSB] == B[MSB]) && (sum_w[MSB]  != A[MSB]);
         OP_SUB:  ovf_d = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
         default: ovf_d = 1'b0;
      endcase
   end

   assign neg_d = res_d[MSB];

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
         ovf_q <= ovf_d;
      end
   end

   assign Negative = neg_q;
   assign Overflow = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign ALU_Out = res_q;
   assign Carry   = carry_q;
   assign isZero  = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes model results, a monitor pops and compares each cycle.
// Negative/Overflow are checked only when ALU_EXT_FLAGS_EN is defined.
module tb_alu;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] A = 8'h00;
   logic [7:0] B = 8'h00;
   logic [2:0] ALU_Code = 3'b000;
   logic [7:0] ALU_Out;
   logic       Carry;
   logic       isZero;
`ifdef ALU_EXT_FLAGS_EN
   logic       Negative;
   logic       Overflow;
`endif

   typedef struct {
      int out;
      bit carry;
      bit zero;
      bit neg;
      bit ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   alu #(.DATA_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .B        (B),
      .ALU_Code (ALU_Code),
      .ALU_Out  (ALU_Out),
      .Carry    (Carry),
`ifdef ALU_EXT_FLAGS_EN
      .Negative (Negative),
      .Overflow (Overflow),
`endif
      .isZero   (isZero)
   );

   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic.
   function automatic exp_t model(input bit r, input int a, input int b, input int code);
      exp_t e;
      int   s, sa, sb;
      e.out = 0; e.carry = 0; e.neg = 0; e.ovf = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      if (r) begin
         e.zero = 1;
         return e;
      end
      case (code)
         0: begin
            s = a + b; e.out = s % 256; e.carry = (s > 255);
            e.ovf = (sa + sb > 127) || (sa + sb < -128);
         end
         1: begin
            e.out = (a - b + 256) % 256; e.carry = (a < b);
            e.ovf = (sa - sb > 127) || (sa - sb < -128);
         end
         2: e.out = a & b;
         3: e.out = a | b;
         4: e.out = a ^ b;
         5: e.out = 255 - a;
         6: begin e.out = (a * 2) % 256; e.carry = (a >= 128); end
         default: begin e.out = a / 2; e.carry = (a % 2 == 1); end
      endcase
      e.zero = (e.out == 0);
      e.neg  = (e.out >= 128);
      return e;
   endfunction

   task automatic issue(input bit r, input int a, input int b, input int code);
      @(negedge clk);
      reset    = r;
      A        = 8'(a);
      B        = 8'(b);
      ALU_Code = 3'(code);
      sb_q.push_back(model(r, a, b, code));
      $display("issue reset=%0b A=%02h B=%02h code=%0d", r, a, b, code);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: inputs driven at a negedge are registered at the next posedge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp("ALU_Out", int'(ALU_Out), e.out);
            cmp("Carry", int'(Carry), int'(e.carry));
            cmp("isZero", int'(isZero), int'(e.zero));
`ifdef ALU_EXT_FLAGS_EN
            cmp("Negative", int'(Negative), int'(e.neg));
            cmp("Overflow", int'(Overflow), int'(e.ovf));
`endif
            $display("check out=%02h carry=%0b zero=%0b exp_out=%02h", ALU_Out, Carry, isZero, e.out);
         end
      end
   end

   initial begin
      int wait_cycles;
      // Reset dominates a presented operation.
      issue(1, 'h55, 'hAA, 0);
      issue(0, 'h01, 'h01, 1);
      issue(0, 'hFF, 'h01, 0);
      issue(0, 'h00, 'h01, 1);
      for (int c = 2; c <= 5; c++) issue(0, 'hF0, 'h3C, c);
      issue(0, 'h81, 'h00, 6);
      issue(0, 'h81, 'h00, 7);
      issue(0, 'h7F, 'h01, 0);
      issue(0, 'h80, 'h01, 1);
      // Mid-stream reset discards the sampled operation.
      issue(1, 'h12, 'h34, 0);
      issue(0, 'h12, 'h34, 0);
      issue(0, 'hA5, 'hA5, 1);
      for (int i = 0; i < 300; i++)
         issue(($urandom_range(0, 19) == 0), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 7));
      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
